fini_dup_check_stage: RTL and testbench
=======================================

Name: fini_dup_check_stage

Overview:
- Output stage directly downstream of the 5-bit FINI AND datapath.
- Receives the result vector from two redundant copies of the AND netlist and registers it behind a valid/ready handshake.
- Forwards only results on which both copies agree. Counts disagreements, which are treated as detected faults.
- Raises a sticky alarm and blocks all traffic once the fault count reaches a threshold.

Parameters:
- WIDTH, 5, data width; equals the AND result width.
- CNT_W, 4, width of the fault counter.
- THRESHOLD, 1, fault count that triggers the alarm. Legal range 1 .. 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  result pair valid.
- in_ready  output  1  stage can accept a pair this cycle.
- res_a  input  WIDTH  result from copy A (port_c of instance A).
- res_b  input  WIDTH  result from copy B (port_c of instance B).
- out_valid  output  1  out_data holds a checked result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  checked result.
- fault_pulse  output  1  one-cycle pulse, registered, on each accepted mismatching pair.
- fault_cnt  output  CNT_W  saturating count of mismatches since reset or clear.
- alarm  output  1  sticky alarm.
- clear_alarm  input  1  synchronous clear of counter and alarm.

Behaviour:
- Reset is asynchronous, active-high:
  - state=RUN, out_valid=0, out_data=0, fault_pulse=0, fault_cnt=0, alarm=0.
  - in_ready is combinational and goes high on reset deassertion.
- States: RUN and ALARM. alarm = (state==ALARM).
- RUN:
  - in_ready = !out_valid | out_ready, giving a single-entry pipeline register with full throughput.
  - accept = in_valid & in_ready.
- Accept with res_a==res_b:
  - Next cycle out_valid=1 and out_data=res_a. Latency is 1 cycle.
- Accept with res_a!=res_b:
  - The pair is dropped and no output is produced.
  - If out_ready pops the current entry in the same cycle, out_valid falls to 0.
  - fault_pulse=1 next cycle.
  - fault_cnt increments, saturating at 2^CNT_W-1.
  - If the incremented count >= THRESHOLD, next state is ALARM.
- Output register:
  - out_valid & out_ready with no accept clears out_valid.
  - out_data is forced to 0 whenever out_valid=0; it never holds stale or unchecked data.
- ALARM:
  - in_ready=0, out_valid=0, out_data=0. Any pending output entry is discarded on entry.
  - fault_cnt holds its value.
  - Leaves only via clear_alarm: next state RUN, fault_cnt=0.
- clear_alarm in RUN: fault_cnt=0.
  - If a mismatching accept occurs in the same cycle, clear applies first, so fault_cnt=1. This can still trigger ALARM when THRESHOLD=1.
- fault_pulse is 0 in every cycle without a mismatching accept.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and the output is held stable.
- Reset mid-transfer: any held result is lost and all outputs return to their reset values asynchronously.
- in_valid, res_a and res_b are sampled only on accept; their values in other cycles are don't-care.

Decomposition:
- Shared package fini_pkg holds:
  - WIDTH default constant.
  - State enum typedef {RUN, ALARM}.
  - Function sat_inc(cnt) for the saturating increment.
- One natural sub-module, fini_out_reg: the single-entry valid/ready register with zero-on-invalid data.
- The checker FSM, counter and comparator live in the top module.

Test Plan:
1. Reset, then res_a=res_b=5'b10110 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_data=5'b10110, fault_cnt=0, alarm=0.
2. Hold out_ready=0 after one accept of 5'b00011, then present a second pair 5'b11100 -> in_ready=0; out_data stays 5'b00011. Raise out_ready -> second pair is accepted and appears the following cycle.
3. THRESHOLD=3: apply three mismatches (5'b00001 vs 5'b00000) interleaved with matches -> fault_pulse pulses three times, fault_cnt goes 1,2,3, alarm=1 after the third; in_ready=0 and out_data=0 while in ALARM.
4. In ALARM, assert clear_alarm for one cycle -> state RUN, fault_cnt=0, in_ready=1; a following matching pair 5'b01010 is forwarded.
5. THRESHOLD=15, CNT_W=4: apply 20 mismatches with clear_alarm low -> fault_cnt saturates at 15 and alarm=1 at the 15th mismatch.
6. Assert rst asynchronously while out_valid=1 with out_data=5'b11111 -> out_valid=0 and out_data=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fini_pkg.sv
// Shared definitions for the FINI duplicate-check output stage: default
// data width, checker state encoding and the saturating counter step.
package fini_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic {
    RUN   = 1'b0,
    ALARM = 1'b1
  } chk_state_t;

  // Increment cnt by one, holding at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/fini_out_reg.sv
// Single-entry valid/ready output register. Data is forced to zero whenever
// the entry is empty, so a consumer can never observe stale or unchecked bits.
module fini_out_reg #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush wins over load; a pop without a load empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && pop) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/fini_dup_check_stage.sv
// Output stage behind two redundant copies of the FINI AND datapath.
// Matching pairs are forwarded through a one-entry register; mismatches are
// dropped and counted, and reaching THRESHOLD locks the stage in ALARM.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the output entry holds stable
// while out_valid=1 and out_ready=0.
//
// The checker state is observable on the alarm output (alarm = state==ALARM).
module fini_dup_check_stage
  import fini_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_a,
  input  logic [WIDTH-1:0] res_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             alarm,
  input  logic             clear_alarm
);

  localparam int unsigned    CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] THR   = CNT_W'(THRESHOLD);

  chk_state_t       state_q;
  chk_state_t       state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             pulse_q;
  logic             accept;
  logic             pair_match;
  logic             good_accept;
  logic             bad_accept;
  logic             flush;

  assign pair_match  = (res_a == res_b);
  assign accept      = in_valid && in_ready;
  assign good_accept = accept && pair_match;
  assign bad_accept  = accept && !pair_match;

  // Clear is applied before a same-cycle mismatch increment.
  assign cnt_base = clear_alarm ? '0 : cnt_q;
  assign cnt_inc  = CNT_W'(sat_inc(32'(cnt_base), 32'(CNT_MAX)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_next;
  end

  // Next-state and next-count logic.
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    case (state_q)
      RUN: begin
        if (bad_accept) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= THR) state_next = ALARM;
        end else if (clear_alarm) begin
          cnt_next = '0;
        end
      end
      ALARM: begin
        if (clear_alarm) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Handshake and flush outputs derived from the current/next state.
  always_comb begin
    in_ready = (state_q == RUN) && (!out_valid || out_ready);
    alarm    = (state_q == ALARM);
    flush    = (state_next == ALARM);
  end

  // Fault counter and registered mismatch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      pulse_q <= bad_accept;
    end
  end

  assign fault_cnt   = cnt_q;
  assign fault_pulse = pulse_q;

  fini_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (good_accept),
    .load_data(res_a),
    .pop      (out_ready),
    .flush    (flush),
    .valid    (out_valid),
    .data     (out_data)
  );

endmodule

// File: tb/tb_fini_dup_check_stage.sv
// Directed bench for fini_dup_check_stage. Three instances with THRESHOLD
// 1, 3 and 15 share the same stimulus; each step checks the instance whose
// threshold the step exercises.
module tb_fini_dup_check_stage;

  localparam int W  = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  res_a;
  logic [W-1:0]  res_b;
  logic          out_ready;
  logic          clear_alarm;

  logic          rdy1, rdy3, rdy15;
  logic          ov1, ov3, ov15;
  logic [W-1:0]  od1, od3, od15;
  logic          fp1, fp3, fp15;
  logic [CW-1:0] fc1, fc3, fc15;
  logic          al1, al3, al15;

  int n_checks;
  int n_errors;

  fini_dup_check_stage #(.WIDTH(W), .CNT_W(CW), .THRESHOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .res_a(res_a), .res_b(res_b), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .fault_pulse(fp1), .fault_cnt(fc1), .alarm(al1),
    .clear_alarm(clear_alarm));

  fini_dup_check_stage #(.WIDTH(W), .CNT_W(CW), .THRESHOLD(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
    .res_a(res_a), .res_b(res_b), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .fault_pulse(fp3), .fault_cnt(fc3), .alarm(al3),
    .clear_alarm(clear_alarm));

  fini_dup_check_stage #(.WIDTH(W), .CNT_W(CW), .THRESHOLD(15)) dut15 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy15),
    .res_a(res_a), .res_b(res_b), .out_valid(ov15), .out_ready(out_ready),
    .out_data(od15), .fault_pulse(fp15), .fault_cnt(fc15), .alarm(al15),
    .clear_alarm(clear_alarm));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair for a single cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    res_a    = a;
    res_b    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    res_a       = '0;
    res_b       = '0;
    out_ready   = 1'b0;
    clear_alarm = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", ov1, 0);
    check("rst_out_data", od1, 0);
    check("rst_fault_pulse", fp1, 0);
    check("rst_fault_cnt", fc1, 0);
    check("rst_alarm", al1, 0);
    check("rst_in_ready", rdy1, 1);

    // 1: matching pair forwarded after one cycle
    out_ready = 1'b1;
    send(5'b10110, 5'b10110);
    check("t1_out_valid", ov1, 1);
    check("t1_out_data", od1, 5'b10110);
    check("t1_fault_cnt", fc1, 0);
    check("t1_alarm", al1, 0);
    check("t1_fault_pulse", fp1, 0);
    tick();
    check("t1_drain_valid", ov1, 0);
    check("t1_drain_data_zero", od1, 0);

    // 2: backpressure holds the entry and blocks input
    out_ready = 1'b0;
    send(5'b00011, 5'b00011);
    check("t2_first_valid", ov1, 1);
    check("t2_first_data", od1, 5'b00011);
    res_a    = 5'b11100;
    res_b    = 5'b11100;
    in_valid = 1'b1;
    #1;
    check("t2_in_ready_low", rdy1, 0);
    tick();
    check("t2_hold_data", od1, 5'b00011);
    tick();
    check("t2_hold_data2", od1, 5'b00011);
    check("t2_hold_valid", ov1, 1);
    out_ready = 1'b1;
    #1;
    check("t2_in_ready_high", rdy1, 1);
    tick();
    in_valid = 1'b0;
    check("t2_second_valid", ov1, 1);
    check("t2_second_data", od1, 5'b11100);
    tick();
    check("t2_drained", ov1, 0);

    // 3: THRESHOLD=3, three mismatches interleaved with matches
    send(5'b00001, 5'b00000);
    check("t3_m1_pulse", fp3, 1);
    check("t3_m1_cnt", fc3, 1);
    check("t3_m1_alarm", al3, 0);
    check("t3_m1_valid", ov3, 0);
    check("t3_thr1_alarm", al1, 1);
    send(5'b01111, 5'b01111);
    check("t3_k1_pulse", fp3, 0);
    check("t3_k1_data", od3, 5'b01111);
    send(5'b00001, 5'b00000);
    check("t3_m2_pulse", fp3, 1);
    check("t3_m2_cnt", fc3, 2);
    check("t3_m2_valid_popped", ov3, 0);
    send(5'b00101, 5'b00101);
    check("t3_k2_data", od3, 5'b00101);
    check("t3_k2_cnt", fc3, 2);
    send(5'b00001, 5'b00000);
    check("t3_m3_pulse", fp3, 1);
    check("t3_m3_cnt", fc3, 3);
    check("t3_m3_alarm", al3, 1);
    check("t3_m3_valid", ov3, 0);
    check("t3_m3_data", od3, 0);
    check("t3_alarm_in_ready", rdy3, 0);
    send(5'b01010, 5'b01010);
    check("t3_blocked_valid", ov3, 0);
    check("t3_blocked_data", od3, 0);
    check("t3_blocked_pulse", fp3, 0);
    check("t3_cnt_hold", fc3, 3);

    // 4: clear_alarm returns to RUN
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    check("t4_alarm", al3, 0);
    check("t4_cnt", fc3, 0);
    check("t4_in_ready", rdy3, 1);
    send(5'b01010, 5'b01010);
    check("t4_valid", ov3, 1);
    check("t4_data", od3, 5'b01010);
    tick();

    // Clear and mismatch in the same cycle: clear first, count becomes 1
    send(5'b00001, 5'b00000);
    check("tc_pre_cnt", fc15, 1);
    clear_alarm = 1'b1;
    send(5'b00001, 5'b00000);
    check("tc_same_cycle_cnt", fc15, 1);
    check("tc_same_cycle_pulse", fp15, 1);
    check("tc_thr1_cleared", al1, 0);
    tick();
    clear_alarm = 1'b0;
    check("tc_cleared_cnt", fc15, 0);

    // 5: THRESHOLD=15, twenty mismatches
    for (int i = 1; i <= 20; i++) begin
      send(5'b00001, 5'b00000);
      check($sformatf("t5_cnt_%0d", i), fc15, (i >= 15) ? 15 : i);
      check($sformatf("t5_alarm_%0d", i), al15, (i >= 15) ? 1 : 0);
      check($sformatf("t5_pulse_%0d", i), fp15, (i <= 15) ? 1 : 0);
      if (i == 1) check("t5_thr1_alarm", al1, 1);
    end

    // 6: asynchronous reset while holding 5'b11111
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    out_ready = 1'b0;
    send(5'b11111, 5'b11111);
    check("t6_pre_valid", ov1, 1);
    check("t6_pre_data", od1, 5'b11111);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", ov1, 0);
    check("t6_async_data", od1, 0);
    check("t6_async_cnt", fc15, 0);
    check("t6_async_alarm", al15, 0);
    #10;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
